// File: rtl/gt_link_sequencer_if.sv
// ----------------------------------------------------------------------------
// gt_link_sequencer_if
//   User-side payload bundle of the GT link sequencer.
//   tx_data  : 16-bit user payload toward the lane
//   tx_valid : payload valid
//   tx_ready : sequencer accepts payload this cycle (tx_valid & tx_ready)
//   rx_data  : 16-bit received word, registered
//   rx_valid : rx_data holds payload (link up, no K characters)
//   modport master : user logic side
//   modport slave  : sequencer side
// ----------------------------------------------------------------------------
interface gt_link_sequencer_if;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] rx_data;
  logic        rx_valid;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/gt_link_sequencer.sv
// ----------------------------------------------------------------------------
// gt_link_sequencer
//   Link bring-up and TX slot scheduler for one 16-bit 8b/10b GT lane.
//   Drives comma realignment, waits a blind period once the GT reports
//   alignment, then verifies that the IDLE comma lands in the upper byte.
//   While up, slot 0 of every g_IDLE_PERIOD slots carries IDLE for clock
//   correction and the other slots carry user payload. Alignment loss, RX
//   buffer over/underflow or a comma in the wrong byte counts an error and
//   retrains.
//
//   Optional feature macro: GT_LINK_SEQ_RETRY_LIMIT_EN
//     defined   : g_MAX_RETRIES consecutive alignment timeouts -> FAULT
//     undefined : ALIGN retries forever, FAULT is unreachable
//
// Ports
//   usrclk_i        GT user clock, the only clock
//   rst_i           synchronous reset, active high
//   en_i            link enable, low forces OFF
//   usr_if          user payload bundle (tx_data/tx_valid/tx_ready,
//                   rx_data/rx_valid); tx_ready is combinational
//   tx_data_o       to GT txdata
//   tx_k_o          to GT txcharisk
//   rx_data_i       from GT rxdata
//   rx_k_i          from GT rxcharisk
//   rx_aligned_i    GT byte-alignment indication
//   rx_bufstatus_i  GT rxbufstatus, bit 2 = over/underflow
//   rx_realign_o    comma realign enable to GT
//   link_up_o       high while in UP
//   state_o         current FSM state
//   err_cnt_o       saturating link error count
// ----------------------------------------------------------------------------
module gt_link_sequencer #(
  parameter logic [15:0] g_IDLE          = 16'hbc95,
  parameter int unsigned g_IDLE_PERIOD   = 193,
  parameter int unsigned g_BLIND_PERIOD  = 10,
  parameter int unsigned g_ALIGN_TIMEOUT = 1023,
  parameter int unsigned g_MAX_RETRIES   = 7
) (
  input  logic                 usrclk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  gt_link_sequencer_if.slave   usr_if,
  output logic [15:0]          tx_data_o,
  output logic [1:0]           tx_k_o,
  input  logic [15:0]          rx_data_i,
  input  logic [1:0]           rx_k_i,
  input  logic                 rx_aligned_i,
  input  logic [2:0]           rx_bufstatus_i,
  output logic                 rx_realign_o,
  output logic                 link_up_o,
  output logic [2:0]           state_o,
  output logic [15:0]          err_cnt_o
);

  localparam int unsigned SLOT_W  = $clog2(g_IDLE_PERIOD);
  localparam int unsigned TMO_W   = $clog2(g_ALIGN_TIMEOUT + 1);
  localparam int unsigned BLIND_W = $clog2(g_BLIND_PERIOD + 1);

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(g_IDLE_PERIOD - 1);
  // The timeout fires on the cycle the counter would reach g_ALIGN_TIMEOUT,
  // so realign drops exactly g_ALIGN_TIMEOUT cycles after entering ALIGN.
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(g_ALIGN_TIMEOUT - 1);
  localparam logic [BLIND_W-1:0] BLIND_LAST = BLIND_W'(g_BLIND_PERIOD);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_ALIGN = 3'd1,
    ST_BLIND = 3'd2,
    ST_CHECK = 3'd3,
    ST_UP    = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  // Saturating increment of the 16-bit error counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    if (val == 16'hFFFF) begin
      sat_inc16 = val;
    end else begin
      sat_inc16 = val + 16'd1;
    end
  endfunction

  state_t               state_q, state_d, fsm_next_s;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [BLIND_W-1:0]   blind_q, blind_d;
  logic [15:0]          err_q, err_d;
  logic                 realign_q, realign_d;
  logic [15:0]          tx_data_q, tx_data_d;
  logic [1:0]           tx_k_q, tx_k_d;
  logic [15:0]          rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 link_up_q, link_up_d;
  logic                 err_inc_s;
  logic                 tmo_pulse_s;
  logic                 tx_ready_s;
  logic                 tx_accept_s;
  logic                 unused_s;

`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
  localparam int unsigned          RETRY_W    = $clog2(g_MAX_RETRIES + 1);
  localparam logic [RETRY_W-1:0]   RETRY_LAST = RETRY_W'(g_MAX_RETRIES - 1);
  logic [RETRY_W-1:0] retry_q, retry_d, retry_next_s;
  assign unused_s = ^rx_bufstatus_i[1:0];
`else
  assign unused_s = ^{rx_bufstatus_i[1:0], (g_MAX_RETRIES == 32'd0)};
`endif

  // Link FSM next state, phase counters and error detection.
  always_comb begin
    fsm_next_s  = state_q;
    tmo_d       = {TMO_W{1'b0}};
    blind_d     = {BLIND_W{1'b0}};
    err_inc_s   = 1'b0;
    tmo_pulse_s = 1'b0;
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
    retry_next_s = retry_q;
`endif
    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          fsm_next_s = ST_ALIGN;
        end else begin
          fsm_next_s = ST_OFF;
        end
      end
      ST_ALIGN: begin
        if (rx_aligned_i) begin
          fsm_next_s = ST_BLIND;
        end else if (tmo_q == TMO_LAST) begin
          // Restart alignment: realign drops for one cycle, counter rewinds.
          tmo_pulse_s = 1'b1;
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
          retry_next_s = retry_q + 1'b1;
          if (retry_q == RETRY_LAST) begin
            fsm_next_s = ST_FAULT;
          end else begin
            fsm_next_s = ST_ALIGN;
          end
`else
          fsm_next_s = ST_ALIGN;
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BLIND: begin
        if (!rx_aligned_i) begin
          fsm_next_s = ST_ALIGN;
        end else if (blind_q >= BLIND_LAST) begin
          // This cycle is aligned cycle number g_BLIND_PERIOD+1.
          fsm_next_s = ST_CHECK;
        end else begin
          blind_d = blind_q + 1'b1;
        end
      end
      ST_CHECK: begin
        if ((rx_k_i == 2'b10) && (rx_data_i == g_IDLE)) begin
          fsm_next_s = ST_UP;
        end else if ((rx_k_i == 2'b01) && (rx_data_i[7:0] == g_IDLE[15:8])) begin
          // Comma landed in the low byte: byte order is swapped.
          err_inc_s  = 1'b1;
          fsm_next_s = ST_ALIGN;
        end else begin
          fsm_next_s = ST_CHECK;
        end
      end
      ST_UP: begin
        // rx_k_i[0] set means a K character in the low byte (01 or 11).
        if (!rx_aligned_i || rx_bufstatus_i[2] || rx_k_i[0]) begin
          err_inc_s  = 1'b1;
          fsm_next_s = ST_ALIGN;
        end else begin
          fsm_next_s = ST_UP;
        end
      end
      ST_FAULT: begin
        fsm_next_s = ST_FAULT;
      end
      default: begin
        fsm_next_s = ST_OFF;
      end
    endcase
  end

  // Enable override, registered-output next values and slot counter.
  always_comb begin
    state_d   = en_i ? fsm_next_s : ST_OFF;
    realign_d = (state_d == ST_ALIGN) && !tmo_pulse_s;
    link_up_d = (state_d == ST_UP);
    if (err_inc_s && en_i) begin
      err_d = sat_inc16(err_q);
    end else begin
      err_d = err_q;
    end
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
    if ((state_d == ST_UP) || (state_d == ST_OFF)) begin
      retry_d = {RETRY_W{1'b0}};
    end else begin
      retry_d = retry_next_s;
    end
`endif
    if (!en_i) begin
      slot_d = {SLOT_W{1'b0}};
    end else if (slot_q == SLOT_LAST) begin
      slot_d = {SLOT_W{1'b0}};
    end else begin
      slot_d = slot_q + 1'b1;
    end
  end

  assign tx_ready_s   = (state_q == ST_UP) && (slot_q != {SLOT_W{1'b0}});
  assign tx_accept_s  = tx_ready_s && usr_if.tx_valid;
  assign usr_if.tx_ready = tx_ready_s;

  // TX word selection and RX capture.
  always_comb begin
    if (tx_accept_s) begin
      tx_data_d = usr_if.tx_data;
      tx_k_d    = 2'b00;
    end else begin
      tx_data_d = g_IDLE;
      tx_k_d    = 2'b10;
    end
    rx_data_d  = rx_data_i;
    rx_valid_d = (state_q == ST_UP) && (rx_k_i == 2'b00);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge usrclk_i) begin
    if (rst_i) begin
      state_q    <= ST_OFF;
      slot_q     <= {SLOT_W{1'b0}};
      tmo_q      <= {TMO_W{1'b0}};
      blind_q    <= {BLIND_W{1'b0}};
      err_q      <= 16'd0;
      realign_q  <= 1'b0;
      tx_data_q  <= g_IDLE;
      tx_k_q     <= 2'b10;
      rx_data_q  <= 16'd0;
      rx_valid_q <= 1'b0;
      link_up_q  <= 1'b0;
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
      retry_q    <= {RETRY_W{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      tmo_q      <= tmo_d;
      blind_q    <= blind_d;
      err_q      <= err_d;
      realign_q  <= realign_d;
      tx_data_q  <= tx_data_d;
      tx_k_q     <= tx_k_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      link_up_q  <= link_up_d;
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign state_o         = state_q;
  assign tx_data_o       = tx_data_q;
  assign tx_k_o          = tx_k_q;
  assign rx_realign_o    = realign_q;
  assign link_up_o       = link_up_q;
  assign err_cnt_o       = err_q;
  assign usr_if.rx_data  = rx_data_q;
  assign usr_if.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_gt_link_sequencer.sv
// ----------------------------------------------------------------------------
// tb_gt_link_sequencer
//   Directed bench for gt_link_sequencer: bring-up timing, IDLE slot
//   cadence, wrong-byte comma, UP faults, alignment timeout and reset.
// ----------------------------------------------------------------------------
module tb_gt_link_sequencer;

  localparam logic [15:0] IDLE = 16'hbc95;
`ifdef GT_LINK_SEQ_RETRY_LIMIT_EN
  localparam int MAX_RETRIES = 2;
  localparam int EXP_LOWS    = 955;
  localparam int EXP_T5_ST   = 5;
`else
  localparam int MAX_RETRIES = 7;
  localparam int EXP_LOWS    = 2;
  localparam int EXP_T5_ST   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] tx_data_o;
  logic [1:0]  tx_k_o;
  logic [15:0] rx_data_i;
  logic [1:0]  rx_k_i;
  logic        rx_aligned_i;
  logic [2:0]  rx_bufstatus_i;
  logic        rx_realign_o;
  logic        link_up_o;
  logic [2:0]  state_o;
  logic [15:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err  = 0;

  gt_link_sequencer_if u_if();

  gt_link_sequencer #(
    .g_MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .usrclk_i       (clk),
    .rst_i          (rst),
    .en_i           (en),
    .usr_if         (u_if),
    .tx_data_o      (tx_data_o),
    .tx_k_o         (tx_k_o),
    .rx_data_i      (rx_data_i),
    .rx_k_i         (rx_k_i),
    .rx_aligned_i   (rx_aligned_i),
    .rx_bufstatus_i (rx_bufstatus_i),
    .rx_realign_o   (rx_realign_o),
    .link_up_o      (link_up_o),
    .state_o        (state_o),
    .err_cnt_o      (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    int k;
    k = 0;
    while ((state_o !== st) && (k < budget)) begin
      step(1);
      k++;
    end
    check_eq(tag, 32'(state_o), 32'(st));
  endtask

  // Present IDLE on RX with alignment and wait for UP.
  task automatic bring_up(input string tag);
    rx_data_i      = IDLE;
    rx_k_i         = 2'b10;
    rx_aligned_i   = 1'b1;
    rx_bufstatus_i = 3'b000;
    wait_state(3'd4, 40, tag);
  endtask

  initial begin
    int first_gap, second_gap, gaps, first_low, second_low, lows;
    logic        r;
    logic [15:0] v;

    rst = 1'b1; en = 1'b0;
    rx_data_i = 16'h0000; rx_k_i = 2'b00; rx_aligned_i = 1'b0; rx_bufstatus_i = 3'b000;
    u_if.tx_data = 16'h0000; u_if.tx_valid = 1'b0;
    step(2);

    // Reset values
    check_eq("rst_state",   32'(state_o), 32'd0);
    check_eq("rst_tx",      32'({tx_k_o, tx_data_o}), 32'({2'b10, IDLE}));
    check_eq("rst_realign", 32'(rx_realign_o), 32'd0);
    check_eq("rst_rxvalid", 32'(u_if.rx_valid), 32'd0);
    check_eq("rst_rxdata",  32'(u_if.rx_data), 32'd0);
    check_eq("rst_linkup",  32'(link_up_o), 32'd0);
    check_eq("rst_err",     32'(err_cnt_o), 32'd0);
    rst = 1'b0;

    // 1: bring-up, aligned after 20 cycles, UP 12 cycles after alignment
    en = 1'b1; rx_data_i = IDLE; rx_k_i = 2'b10;
    step(1);
    check_eq("t1_align", 32'(state_o), 32'd1);
    check_eq("t1_realign", 32'(rx_realign_o), 32'd1);
    step(19);
    check_eq("t1_still_align", 32'(state_o), 32'd1);
    rx_aligned_i = 1'b1;
    step(1);
    check_eq("t1_blind", 32'(state_o), 32'd2);
    check_eq("t1_realign_off", 32'(rx_realign_o), 32'd0);
    step(10);
    check_eq("t1_blind_end", 32'(state_o), 32'd2);
    step(1);
    check_eq("t1_check", 32'(state_o), 32'd3);
    check_eq("t1_linkup_lo", 32'(link_up_o), 32'd0);
    step(1);
    check_eq("t1_up", 32'(state_o), 32'd4);
    check_eq("t1_linkup", 32'(link_up_o), 32'd1);
    check_eq("t1_err", 32'(err_cnt_o), 32'd0);

    // RX path: payload valid only for k=00, data loads every cycle
    rx_k_i = 2'b00; rx_data_i = 16'h1234;
    step(1);
    check_eq("rx_valid", 32'(u_if.rx_valid), 32'd1);
    check_eq("rx_data", 32'(u_if.rx_data), 32'h1234);
    rx_k_i = 2'b10; rx_data_i = IDLE;
    step(1);
    check_eq("rx_valid_k", 32'(u_if.rx_valid), 32'd0);
    check_eq("rx_data_k", 32'(u_if.rx_data), 32'(IDLE));

    // 2: IDLE slot cadence with continuous valid
    u_if.tx_valid = 1'b1;
    step(1);
    first_gap = -1; second_gap = -1; gaps = 0;
    for (int it = 0; it < 386; it++) begin
      v = 16'h1000 + 16'(it);
      u_if.tx_data = v;
      r = u_if.tx_ready;
      if (!r) begin
        gaps++;
        if (first_gap < 0) first_gap = it;
        else if (second_gap < 0) second_gap = it;
      end
      step(1);
      if (r) check_eq("t2_payload", 32'({tx_k_o, tx_data_o}), 32'({2'b00, v}));
      else   check_eq("t2_idle", 32'({tx_k_o, tx_data_o}), 32'({2'b10, IDLE}));
    end
    check_eq("t2_gaps", 32'(gaps), 32'd2);
    check_eq("t2_period", 32'(second_gap - first_gap), 32'd193);
    u_if.tx_valid = 1'b0;

    // 4: buffer fault and alignment loss in one cycle -> one error
    rx_bufstatus_i = 3'b101; rx_aligned_i = 1'b0;
    step(1);
    exp_err++;
    check_eq("t4_state", 32'(state_o), 32'd1);
    check_eq("t4_err", 32'(err_cnt_o), 32'(exp_err));
    check_eq("t4_realign", 32'(rx_realign_o), 32'd1);
    check_eq("t4_ready", 32'(u_if.tx_ready), 32'd0);
    check_eq("t4_linkup", 32'(link_up_o), 32'd0);
    rx_bufstatus_i = 3'b000;

    // 3: wrong byte comma in CHECK
    rx_aligned_i = 1'b1; rx_k_i = 2'b00; rx_data_i = 16'h0000;
    wait_state(3'd3, 30, "t3_reach_check");
    step(2);
    check_eq("t3_k00_ignored", 32'(state_o), 32'd3);
    rx_k_i = 2'b01; rx_data_i = 16'h00bc;
    step(1);
    exp_err++;
    check_eq("t3_state", 32'(state_o), 32'd1);
    check_eq("t3_err", 32'(err_cnt_o), 32'(exp_err));
    check_eq("t3_realign", 32'(rx_realign_o), 32'd1);

    // K character in the low byte while UP
    bring_up("k11_up");
    rx_k_i = 2'b11;
    step(1);
    exp_err++;
    check_eq("k11_state", 32'(state_o), 32'd1);
    check_eq("k11_err", 32'(err_cnt_o), 32'(exp_err));

    // 5: alignment timeout
    bring_up("t5_up");
    rx_aligned_i = 1'b0;
    first_low = -1; second_low = -1; lows = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) step(1);
      else begin
        step(1);
        exp_err++;
        check_eq("t5_err", 32'(err_cnt_o), 32'(exp_err));
      end
      if (rx_realign_o == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = n;
        else if (second_low < 0) second_low = n;
      end
    end
    check_eq("t5_first_low", 32'(first_low), 32'd1023);
    check_eq("t5_second_low", 32'(second_low), 32'd2046);
    check_eq("t5_low_count", 32'(lows), 32'(EXP_LOWS));
    check_eq("t5_state", 32'(state_o), 32'(EXP_T5_ST));
    en = 1'b0;
    step(1);
    check_eq("t5_off", 32'(state_o), 32'd0);
    check_eq("t5_off_realign", 32'(rx_realign_o), 32'd0);

    // 6: reset while UP with traffic
    en = 1'b1;
    bring_up("t6_up");
    u_if.tx_valid = 1'b1; u_if.tx_data = 16'h5a5a;
    rx_k_i = 2'b00; rx_data_i = 16'h00ff;
    step(3);
    check_eq("t6_pre_valid", 32'(u_if.rx_valid), 32'd1);
    rst = 1'b1;
    step(1);
    check_eq("t6_state",   32'(state_o), 32'd0);
    check_eq("t6_tx",      32'({tx_k_o, tx_data_o}), 32'({2'b10, IDLE}));
    check_eq("t6_realign", 32'(rx_realign_o), 32'd0);
    check_eq("t6_rxdata",  32'(u_if.rx_data), 32'd0);
    check_eq("t6_rxvalid", 32'(u_if.rx_valid), 32'd0);
    check_eq("t6_linkup",  32'(link_up_o), 32'd0);
    check_eq("t6_err",     32'(err_cnt_o), 32'd0);
    check_eq("t6_ready",   32'(u_if.tx_ready), 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
